scan_sequencer: RTL

SCAN_SEQUENCER -- requirements
Module: scan_sequencer

---
 rtl/scan_sequencer.sv | 113 +++++++++++
 1 files changed

// File: rtl/scan_sequencer.sv
// scan_sequencer: steps the 6:64 decoder address 0..LAST, holding each address dwell+1 cycles; optional wrap.
// Latency: start/stop act at the next rising edge; all outputs come straight from registers.
// Backpressure: none; `define SCAN_PAUSE_EN adds a pause input that freezes an active scan.
module scan_sequencer #(
    parameter int LAST    = 63,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               stop,
    input  logic               continuous,
    input  logic [DWELL_W-1:0] dwell,
`ifdef SCAN_PAUSE_EN
    input  logic               pause,
`endif
    output logic [5:0]         addr,
    output logic               addr_valid,
    output logic               busy,
    output logic               done
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic [5:0]         LAST_A  = 6'(LAST);
    localparam logic [DWELL_W-1:0] CNT_ONE = DWELL_W'(1);

    state_t             state_q, state_d;
    logic [5:0]         addr_q, addr_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               cont_q, cont_d;
    logic               done_q, done_d;
    logic               pause_w;

`ifdef SCAN_PAUSE_EN
    assign pause_w = pause;
`else
    assign pause_w = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            dwell_q <= '0;
            cont_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
            cont_q  <= cont_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        dwell_d = dwell_q;
        cont_d  = cont_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // stop wins over a simultaneous start
                if (start && !stop) begin
                    state_d = SCAN;
                    addr_d  = '0;
                    dwell_d = dwell;
                    cont_d  = continuous;
                    cnt_d   = dwell;
                end
            end
            SCAN: begin
                if (stop) begin
                    state_d = IDLE;
                    addr_d  = '0;
                end else if (!pause_w) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end else if (addr_q != LAST_A) begin
                        addr_d = addr_q + 6'd1;
                        cnt_d  = dwell_q;
                    end else if (cont_q) begin
                        addr_d = '0;
                        cnt_d  = dwell_q;
                    end else begin
                        state_d = IDLE;
                        addr_d  = '0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                addr_d  = '0;
            end
        endcase
    end

    assign addr       = addr_q;
    assign busy       = (state_q == SCAN);
    assign addr_valid = (state_q == SCAN);
    assign done       = done_q;

endmodule
